// File: rtl/board_clear_ctrl.sv
// Tetris board occupancy store: locks 4-block pieces, removes completed rows
// by shifting the rows above down, and serves a registered row read port.
module board_clear_ctrl #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int ROW_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             new_game,
  input  logic             lock_req,
  input  logic [6:0]       lock_x [4],
  input  logic [6:0]       lock_y [4],
  output logic             lock_ack,
  output logic [2:0]       lines_cleared,
  output logic             busy,
  output logic             game_over,
  output logic             coord_err,
  input  logic [4:0]       rd_addr,
  output logic [ROW_W-1:0] rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOCK  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [6:0]       COLS_W   = 7'(COLS);
  localparam logic [6:0]       ROWS_W   = 7'(ROWS);
  localparam logic [4:0]       ROWS_A   = 5'(ROWS);
  localparam logic [4:0]       LAST_ROW = 5'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};

  state_t           state_r;
  logic [ROW_W-1:0] board_r [ROWS];
  logic [6:0]       lx_r [4];
  logic [6:0]       ly_r [4];
  logic [4:0]       r_r;
  logic [4:0]       s_r;

  logic [3:0]       in_rng_s;
  logic             req_oob_s;
  logic             hit_s;
  logic             row_full_s;

  // Range/overlap decode; coord_err is judged on the live request so it can pulse during LOCK
  always_comb begin
    req_oob_s = 1'b0;
    hit_s     = 1'b0;
    in_rng_s  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_rng_s[i] = (lx_r[i] < COLS_W) && (ly_r[i] < ROWS_W);
      req_oob_s   = req_oob_s | (lock_x[i] >= COLS_W) | (lock_y[i] >= ROWS_W);
      hit_s       = hit_s | (ly_r[i] == 7'd0) |
                    (in_rng_s[i] && board_r[ly_r[i][4:0]][lx_r[i][3:0]]);
    end
    row_full_s = &board_r[r_r][COLS-1:0];
  end

  // Sequencer, board storage and all registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= ST_IDLE;
      r_r           <= 5'd0;
      s_r           <= 5'd0;
      rd_data       <= ROW_ZERO;
      lock_ack      <= 1'b0;
      lines_cleared <= 3'd0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      coord_err     <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        board_r[r] <= ROW_ZERO;
      end
      for (int i = 0; i < 4; i++) begin
        lx_r[i] <= 7'd0;
        ly_r[i] <= 7'd0;
      end
    end else begin
      lock_ack  <= 1'b0;
      coord_err <= 1'b0;
      rd_data   <= (rd_addr < ROWS_A) ? board_r[rd_addr] : ROW_ZERO;
      case (state_r)
        ST_IDLE: begin
          if (new_game) begin
            for (int r = 0; r < ROWS; r++) begin
              board_r[r] <= ROW_ZERO;
            end
            game_over <= 1'b0;
          end else if (lock_req) begin
            lx_r          <= lock_x;
            ly_r          <= lock_y;
            lines_cleared <= 3'd0;
            coord_err     <= req_oob_s;
            busy          <= 1'b1;
            state_r       <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          for (int i = 0; i < 4; i++) begin
            if (in_rng_s[i]) begin
              board_r[ly_r[i][4:0]][lx_r[i][3:0]] <= 1'b1;
            end
          end
          if (hit_s) begin
            game_over <= 1'b1;
          end
          r_r     <= LAST_ROW;
          state_r <= ST_SCAN;
        end
        ST_SCAN: begin
          if (row_full_s) begin
            if (lines_cleared != 3'd4) begin
              lines_cleared <= lines_cleared + 3'd1;
            end
            s_r     <= r_r;
            state_r <= ST_SHIFT;
          end else if (r_r == 5'd0) begin
            lock_ack <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            r_r <= r_r - 5'd1;
          end
        end
        ST_SHIFT: begin
          // r_r is left alone so the row that drops into it gets rescanned
          if (s_r != 5'd0) begin
            board_r[s_r] <= board_r[s_r - 5'd1];
            s_r          <= s_r - 5'd1;
          end else begin
            board_r[0] <= ROW_ZERO;
            state_r    <= ST_SCAN;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_clear_ctrl.sv
// Randomised and directed bench for board_clear_ctrl against a row-list
// reference model of locking, line removal and sequence latency.
module tb_board_clear_ctrl;

  localparam int ROWS  = 20;
  localparam int COLS  = 10;
  localparam int ROW_W = 16;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             new_game = 1'b0;
  logic             lock_req = 1'b0;
  logic [6:0]       lock_x [4];
  logic [6:0]       lock_y [4];
  logic             lock_ack;
  logic [2:0]       lines_cleared;
  logic             busy;
  logic             game_over;
  logic             coord_err;
  logic [4:0]       rd_addr = 5'd0;
  logic [ROW_W-1:0] rd_data;

  int total = 0;
  int bad   = 0;

  logic [ROW_W-1:0] mb [ROWS];
  logic             go_m;
  logic [6:0]       cx [4];
  logic [6:0]       cy [4];

  board_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .new_game(new_game), .lock_req(lock_req),
    .lock_x(lock_x), .lock_y(lock_y), .lock_ack(lock_ack),
    .lines_cleared(lines_cleared), .busy(busy), .game_over(game_over),
    .coord_err(coord_err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) mb[r] = 16'h0000;
    go_m = 1'b0;
  endtask

  // Board as a list of rows: full rows are dropped, survivors settle to the bottom
  task automatic model_lock(output logic ce, output int lat, output int lc);
    logic [ROW_W-1:0] old [ROWS];
    logic [ROW_W-1:0] nb [ROWS];
    logic [4:0]       y5;
    logic [3:0]       x4;
    int               k;
    int               idx;
    old = mb;
    ce  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cx[i] < 7'd10 && cy[i] < 7'd20) begin
        y5 = cy[i][4:0];
        x4 = cx[i][3:0];
        if (old[y5][x4]) go_m = 1'b1;
        mb[y5][x4] = 1'b1;
      end else begin
        ce = 1'b1;
      end
      if (cy[i] == 7'd0) go_m = 1'b1;
    end
    for (int r = 0; r < ROWS; r++) nb[r] = 16'h0000;
    k   = 0;
    idx = ROWS - 1;
    lat = 2 + ROWS;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (mb[r][COLS-1:0] == 10'h3FF) begin
        // found at its original index plus the rows already removed below it
        lat += r + k + 2;
        k++;
      end else begin
        nb[idx] = mb[r];
        idx--;
      end
    end
    lc = (k > 4) ? 4 : k;
    mb = nb;
  endtask

  task automatic set_piece(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3);
    cx[0] = 7'(x0); cy[0] = 7'(y0);
    cx[1] = 7'(x1); cy[1] = 7'(y1);
    cx[2] = 7'(x2); cy[2] = 7'(y2);
    cx[3] = 7'(x3); cy[3] = 7'(y3);
  endtask

  task automatic check_board();
    for (int r = 0; r < ROWS; r++) begin
      @(negedge Clk);
      rd_addr = 5'(r);
      @(posedge Clk);
      #1;
      chk($sformatf("row%0d", r), 32'(rd_data), 32'(mb[r]));
    end
    @(negedge Clk);
    rd_addr = 5'(20 + $urandom_range(0, 11));
    @(posedge Clk);
    #1;
    chk("row_oob", 32'(rd_data), 32'h0);
  endtask

  task automatic run_lock();
    logic ce;
    int   lat;
    int   lc;
    int   j;
    logic got;
    model_lock(ce, lat, lc);
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      lock_x[i] = cx[i];
      lock_y[i] = cy[i];
    end
    lock_req = 1'b1;
    @(posedge Clk);
    #1;
    j = 1;
    chk("busy_n1", 32'(busy), 32'h1);
    chk("coord_err_n1", 32'(coord_err), 32'(ce));
    // coordinates must already be captured; garbage from here on
    for (int i = 0; i < 4; i++) begin
      lock_x[i] = 7'($urandom);
      lock_y[i] = 7'($urandom);
    end
    got = 1'b0;
    while (!got && j < 400) begin
      @(posedge Clk);
      #1;
      j++;
      if (j == 2) begin
        chk("coord_err_n2", 32'(coord_err), 32'h0);
        chk("game_over_lock", 32'(game_over), 32'(go_m));
      end
      got = lock_ack;
    end
    chk("ack_cycle", got ? 32'(j) : 32'h0, 32'(lat));
    chk("lines_cleared", 32'(lines_cleared), 32'(lc));
    @(negedge Clk);
    lock_req = 1'b0;
    @(posedge Clk);
    #1;
    chk("ack_one_cycle", 32'(lock_ack), 32'h0);
    chk("busy_end", 32'(busy), 32'h0);
    chk("lines_hold", 32'(lines_cleared), 32'(lc));
    chk("game_over_hold", 32'(game_over), 32'(go_m));
    check_board();
  endtask

  task automatic do_new_game();
    @(negedge Clk);
    new_game = 1'b1;
    lock_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lock_x[i] = 7'd1;
      lock_y[i] = 7'd19;
    end
    @(posedge Clk);
    #1;
    chk("newgame_no_lock", 32'(busy), 32'h0);
    @(negedge Clk);
    new_game = 1'b0;
    lock_req = 1'b0;
    @(posedge Clk);
    #1;
    chk("newgame_busy", 32'(busy), 32'h0);
    chk("newgame_go", 32'(game_over), 32'h0);
    model_clear();
    check_board();
  endtask

  task automatic gen_piece();
    for (int i = 0; i < 4; i++) begin
      cx[i] = 7'($urandom_range(0, 9));
      cy[i] = 7'(19 - $urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) cx[i] = 7'($urandom_range(10, 127));
      if ($urandom_range(0, 15) == 0) cy[i] = 7'd0;
      if ($urandom_range(0, 19) == 0) cy[i] = 7'($urandom_range(20, 127));
    end
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 4; i++) begin
      lock_x[i] = 7'd0;
      lock_y[i] = 7'd0;
    end
    model_clear();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_go", 32'(game_over), 32'h0);
    chk("rst_ack", 32'(lock_ack), 32'h0);
    chk("rst_lines", 32'(lines_cleared), 32'h0);
    chk("rst_cerr", 32'(coord_err), 32'h0);
    check_board();

    // flat piece on an empty board
    set_piece(0, 19, 1, 19, 2, 19, 3, 19);
    run_lock();
    // onto an occupied cell
    set_piece(0, 19, 5, 10, 6, 10, 7, 10);
    run_lock();
    do_new_game();
    // block in the top row
    set_piece(4, 0, 4, 1, 4, 2, 4, 3);
    run_lock();
    do_new_game();

    // row 19 = 03F0, row 18 = 0001, then complete row 19
    set_piece(4, 19, 5, 19, 6, 19, 7, 19);
    run_lock();
    set_piece(8, 19, 9, 19, 0, 18, 0, 18);
    run_lock();
    set_piece(0, 19, 1, 19, 2, 19, 3, 19);
    run_lock();
    do_new_game();

    // rows 16..19 = 03FE, then a vertical I at x=0
    for (int x = 1; x < 10; x++) begin
      set_piece(x, 16, x, 17, x, 18, x, 19);
      run_lock();
    end
    set_piece(0, 16, 0, 17, 0, 18, 0, 19);
    run_lock();

    // one out-of-range column
    set_piece(10, 19, 1, 19, 2, 19, 3, 19);
    run_lock();
    do_new_game();

    // reset in the middle of SHIFT
    set_piece(4, 19, 5, 19, 6, 19, 7, 19);
    run_lock();
    set_piece(8, 19, 9, 19, 9, 19, 8, 19);
    run_lock();
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      lock_x[i] = 7'(i);
      lock_y[i] = 7'd19;
    end
    lock_req = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("shift_busy", 32'(busy), 32'h1);
    chk("shift_lines", 32'(lines_cleared), 32'h1);
    Reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ack", 32'(lock_ack), 32'h0);
    chk("arst_lines", 32'(lines_cleared), 32'h0);
    chk("arst_go", 32'(game_over), 32'h0);
    chk("arst_cerr", 32'(coord_err), 32'h0);
    chk("arst_rd", 32'(rd_data), 32'h0);
    @(negedge Clk);
    lock_req = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge Clk);
      #1;
      if (lock_ack || busy) seen = 1'b1;
    end
    chk("arst_no_ack", 32'(seen), 32'h0);
    model_clear();
    check_board();

    // random play
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 9) do_new_game();
      gen_piece();
      run_lock();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
